// File: rtl/dac_seq_pkg.sv
// Shared constants, FSM state type and channel pick helper for the AD8803 sequencer.
package dac_seq_pkg;

    localparam int NumCh = 8;

    localparam logic [3:0] AddrCtrl    = 4'h8;
    localparam logic [3:0] AddrStatus  = 4'h9;
    localparam logic [3:0] AddrRefresh = 4'hA;

    localparam int CtrlUpdAll   = 0;
    localparam int CtrlUpdDirty = 1;
    localparam int CtrlClrErr   = 2;

    localparam int StatBusy   = 0;
    localparam int StatErr    = 1;
    localparam int StatChLo   = 2;
    localparam int StatPendLo = 8;

    typedef enum logic [2:0] {
        StIdle,
        StScan,
        StAssert,
        StWaitDone,
        StWaitRel
    } seq_state_e;

    // Index of the lowest set bit; 0 when the mask is empty.
    function automatic logic [2:0] lowest_set(input logic [NumCh-1:0] mask);
        logic [2:0] idx;
        idx = '0;
        for (int i = NumCh - 1; i >= 0; i--) begin
            if (mask[i]) idx = 3'(i);
        end
        return idx;
    endfunction

endpackage

// File: rtl/dac_seq_sync.sv
// Two-flop synchroniser for a single level signal, asynchronously cleared to 0.
module dac_seq_sync (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic dout
);

    logic meta_q;
    logic sync_q;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            meta_q <= 1'b0;
            sync_q <= 1'b0;
        end else begin
            meta_q <= din;
            sync_q <= meta_q;
        end
    end

    assign dout = sync_q;

endmodule

// File: rtl/dac_ad8803_sequencer.sv
// Holds the eight AD8803 channel values on OPB and streams requested channels to the writer.
// Periodic full refresh is built only when DAC_SEQ_AUTO_REFRESH_EN is defined.
module dac_ad8803_sequencer
    import dac_seq_pkg::*;
#(
    parameter int unsigned TIMEOUT_CYCLES = 65535,
    parameter int unsigned REFRESH_UNIT   = 1024
) (
    input  logic        OPB_CLK,
    input  logic        OPB_RST,
    input  logic [15:0] OPB_DI,
    input  logic [3:0]  OPB_ADDR,
    input  logic        OPB_WE,
    input  logic        OPB_RE,
    output logic [31:0] OPB_DO,
    output logic        DAC_TRIG,
    output logic [7:0]  DAC_DATA,
    output logic [2:0]  DAC_ADDR,
    input  logic        DAC_DONE,
    output logic        BUSY
);

    localparam logic [15:0] TmoLast = 16'(TIMEOUT_CYCLES - 1);

    logic [7:0]       ch_q [NumCh];
    logic [NumCh-1:0] dirty_q, dirty_d;
    logic [NumCh-1:0] pending_q, pending_d;
    logic             err_q, err_d;
    seq_state_e       state_q, state_d;
    logic             dac_trig_q, dac_trig_d;
    logic [7:0]       dac_data_q, dac_data_d;
    logic [2:0]       dac_addr_q, dac_addr_d;
    logic [15:0]      tmo_cnt_q, tmo_cnt_d;

    logic             done_sync;
    logic             wr_ch, wr_ctrl, wr_refresh;
    logic             clr_err;
    logic [NumCh-1:0] upd_mask;
    logic             refresh_req;
    logic [15:0]      refresh_rd;
    logic [2:0]       scan_ch;
    logic             abort;
    logic             rd_en;
    logic [31:0]      rd_data;

    dac_seq_sync u_done_sync (
        .clk  (OPB_CLK),
        .rst  (OPB_RST),
        .din  (DAC_DONE),
        .dout (done_sync)
    );

    assign wr_ch      = OPB_WE && !OPB_ADDR[3];
    assign wr_ctrl    = OPB_WE && (OPB_ADDR == AddrCtrl);
    assign wr_refresh = OPB_WE && (OPB_ADDR == AddrRefresh);
    assign clr_err    = wr_ctrl && OPB_DI[CtrlClrErr];

    // UPDATE_ALL covers UPDATE_DIRTY, so both bits together simply request everything.
    always_comb begin
        upd_mask = '0;
        if ((wr_ctrl && OPB_DI[CtrlUpdAll]) || refresh_req) begin
            upd_mask = '1;
        end else if (wr_ctrl && OPB_DI[CtrlUpdDirty]) begin
            upd_mask = dirty_q;
        end
    end

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            for (int i = 0; i < NumCh; i++) ch_q[i] <= '0;
        end else if (wr_ch) begin
            ch_q[OPB_ADDR[2:0]] <= OPB_DI[7:0];
        end
    end

    always_comb begin
        state_d    = state_q;
        pending_d  = pending_q;
        dirty_d    = dirty_q;
        err_d      = err_q;
        dac_trig_d = dac_trig_q;
        dac_data_d = dac_data_q;
        dac_addr_d = dac_addr_q;
        tmo_cnt_d  = tmo_cnt_q;
        abort      = 1'b0;
        scan_ch    = lowest_set(pending_q);

        unique case (state_q)
            StIdle: begin
                if (pending_q != '0) state_d = StScan;
            end
            StScan: begin
                dac_data_d         = ch_q[scan_ch];
                dac_addr_d         = scan_ch;
                pending_d[scan_ch] = 1'b0;
                dirty_d[scan_ch]   = 1'b0;
                dac_trig_d         = 1'b1;
                state_d            = StAssert;
            end
            StAssert: begin
                tmo_cnt_d = '0;
                state_d   = StWaitDone;
            end
            StWaitDone: begin
                if (done_sync) begin
                    dac_trig_d = 1'b0;
                    tmo_cnt_d  = '0;
                    state_d    = StWaitRel;
                end else if (tmo_cnt_q == TmoLast) begin
                    abort = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            StWaitRel: begin
                if (!done_sync) begin
                    state_d = (pending_q != '0) ? StScan : StIdle;
                end else if (tmo_cnt_q == TmoLast) begin
                    abort = 1'b1;
                end else begin
                    tmo_cnt_d = tmo_cnt_q + 16'd1;
                end
            end
            default: state_d = StIdle;
        endcase

        if (clr_err) err_d = 1'b0;

        if (abort) begin
            dac_trig_d = 1'b0;
            pending_d  = '0;
            err_d      = 1'b1;
            state_d    = StIdle;
        end

        // A channel write landing on the same edge as its scan keeps the channel dirty.
        if (wr_ch) dirty_d[OPB_ADDR[2:0]] = 1'b1;

        pending_d = pending_d | upd_mask;
    end

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            state_q    <= StIdle;
            pending_q  <= '0;
            dirty_q    <= '0;
            err_q      <= 1'b0;
            dac_trig_q <= 1'b0;
            dac_data_q <= '0;
            dac_addr_q <= '0;
            tmo_cnt_q  <= '0;
        end else begin
            state_q    <= state_d;
            pending_q  <= pending_d;
            dirty_q    <= dirty_d;
            err_q      <= err_d;
            dac_trig_q <= dac_trig_d;
            dac_data_q <= dac_data_d;
            dac_addr_q <= dac_addr_d;
            tmo_cnt_q  <= tmo_cnt_d;
        end
    end

`ifdef DAC_SEQ_AUTO_REFRESH_EN
    localparam int unsigned UnitW = (REFRESH_UNIT > 1) ? $clog2(REFRESH_UNIT) : 1;
    localparam logic [UnitW-1:0] UnitLast = UnitW'(REFRESH_UNIT - 1);

    logic [UnitW-1:0] unit_cnt_q;
    logic [15:0]      refresh_q;
    logic [15:0]      refresh_cnt_q;
    logic             refresh_hold_q;
    logic             tick;

    assign tick = (unit_cnt_q == UnitLast);

    always_ff @(posedge OPB_CLK or posedge OPB_RST) begin
        if (OPB_RST) begin
            unit_cnt_q     <= '0;
            refresh_q      <= '0;
            refresh_cnt_q  <= '0;
            refresh_hold_q <= 1'b0;
        end else begin
            unit_cnt_q <= tick ? '0 : unit_cnt_q + 1'b1;
            if (refresh_req) refresh_hold_q <= 1'b0;
            if (wr_refresh) begin
                refresh_q     <= OPB_DI;
                refresh_cnt_q <= OPB_DI;
            end else if (tick && (refresh_q != '0)) begin
                if (refresh_cnt_q > 16'd1) begin
                    refresh_cnt_q <= refresh_cnt_q - 16'd1;
                end else begin
                    refresh_cnt_q  <= refresh_q;
                    refresh_hold_q <= 1'b1;
                end
            end
        end
    end

    // Held requests wait for IDLE so a running pass is never reordered.
    assign refresh_req = refresh_hold_q && (state_q == StIdle);
    assign refresh_rd  = refresh_q;
`else
    logic unused_refresh;

    assign refresh_req    = 1'b0;
    assign refresh_rd     = '0;
    assign unused_refresh = wr_refresh ^ (^OPB_DI[15:8]);
`endif

    always_comb begin
        rd_data = '0;
        if (!OPB_ADDR[3]) begin
            rd_data[7:0] = ch_q[OPB_ADDR[2:0]];
        end else if (OPB_ADDR == AddrStatus) begin
            rd_data[StatBusy]           = (state_q != StIdle);
            rd_data[StatErr]            = err_q;
            rd_data[StatChLo +: 3]      = dac_addr_q;
            rd_data[StatPendLo +: NumCh] = pending_q;
        end else if (OPB_ADDR == AddrRefresh) begin
            rd_data[15:0] = refresh_rd;
        end
    end

    assign rd_en  = OPB_RE && (OPB_ADDR <= AddrRefresh);
    assign OPB_DO = rd_en ? rd_data : 32'bz;

    assign DAC_TRIG = dac_trig_q;
    assign DAC_DATA = dac_data_q;
    assign DAC_ADDR = dac_addr_q;
    assign BUSY     = (state_q != StIdle);

endmodule
